// File: rtl/router_pkg.sv
// Shared router types: arbitration state, port count and requester id.
package router_pkg;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

   localparam int NUM_ARB_PORTS = 4;

   typedef logic [1:0] port_id_t;

endpackage

// File: rtl/rr_output_arbiter_if.sv
// Requester-side and output-side handshake bundle of the output arbiter.
interface rr_output_arbiter_if
   import router_pkg::*;
#(
   parameter int n = 32
);
   logic [NUM_ARB_PORTS-1:0]         in_valid;
   logic [NUM_ARB_PORTS-1:0]         in_tail;
   logic [NUM_ARB_PORTS-1:0][n-1:0]  in_data;
   logic [NUM_ARB_PORTS-1:0]         in_ready;
   logic                             out_valid;
   logic                             out_tail;
   logic [n-1:0]                     out_data;
   logic                             out_ready;
   port_id_t                         out_src;
   logic                             busy;

   modport master (
      output in_valid, in_tail, in_data, out_ready,
      input  in_ready, out_valid, out_tail, out_data, out_src, busy
   );

   modport slave (
      input  in_valid, in_tail, in_data, out_ready,
      output in_ready, out_valid, out_tail, out_data, out_src, busy
   );
endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate requests so ptr is bit 0, take the lowest set bit, un-rotate.
module rr_priority_pick
   import router_pkg::*;
(
   input  logic [NUM_ARB_PORTS-1:0] req,
   input  port_id_t                 ptr,
   output port_id_t                 winner,
   output logic                     any
);
   logic [NUM_ARB_PORTS-1:0] rot;
   port_id_t                 offset;

   // Two-bit index arithmetic wraps naturally modulo the port count.
   for (genvar gi = 0; gi < NUM_ARB_PORTS; gi++) begin : g_rot
      assign rot[gi] = req[port_id_t'(gi) + ptr];
   end

   always_comb begin
      offset = '0;
      for (int i = NUM_ARB_PORTS - 1; i >= 0; i--) begin
         if (rot[i]) offset = port_id_t'(i);
      end
   end

   assign winner = ptr + offset;
   assign any    = |req;
endmodule

// File: rtl/rr_output_arbiter.sv
// Packet-locking four-way round-robin arbiter feeding one registered output slot.
module rr_output_arbiter
   import router_pkg::*;
#(
   parameter int n           = 32,
   parameter int BURST_LIMIT = 0
) (
   input  logic              clk,
   input  logic              rst,
   rr_output_arbiter_if.slave bus
);
   localparam int CNT_W = (BURST_LIMIT > 0) ? $clog2(BURST_LIMIT + 1) : 1;

   arb_state_t                state_reg, state_next;
   port_id_t                  ptr_reg, ptr_next;
   port_id_t                  gnt_reg, gnt_next;
   logic [CNT_W-1:0]          cnt_reg, cnt_next;
   logic                      valid_reg, valid_next;
   logic                      tail_reg, tail_next;
   logic [n-1:0]              data_reg, data_next;
   port_id_t                  src_reg, src_next;

   port_id_t                  winner;
   logic                      any_req;
   logic                      slot_free;
   logic                      xfer;
   logic                      rel_now;
   logic [NUM_ARB_PORTS-1:0]  ready_vec;

   rr_priority_pick u_pick (
      .req    (bus.in_valid),
      .ptr    (ptr_reg),
      .winner (winner),
      .any    (any_req)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ARB_IDLE;
         ptr_reg   <= '0;
         gnt_reg   <= '0;
         cnt_reg   <= '0;
         valid_reg <= 1'b0;
         tail_reg  <= 1'b0;
         data_reg  <= '0;
         src_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         gnt_reg   <= gnt_next;
         cnt_reg   <= cnt_next;
         valid_reg <= valid_next;
         tail_reg  <= tail_next;
         data_reg  <= data_next;
         src_reg   <= src_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      gnt_next   = gnt_reg;
      cnt_next   = cnt_reg;
      valid_next = valid_reg;
      tail_next  = tail_reg;
      data_next  = data_reg;
      src_next   = src_reg;
      ready_vec  = '0;
      xfer       = 1'b0;
      rel_now    = 1'b0;
      // Ready only looks at registered state and out_ready, never at in_valid.
      slot_free  = !valid_reg || bus.out_ready;

      unique case (state_reg)
         ARB_IDLE: begin
            if (any_req) begin
               gnt_next   = winner;
               cnt_next   = '0;
               state_next = ARB_LOCKED;
            end
         end
         ARB_LOCKED: begin
            ready_vec[gnt_reg] = slot_free;
            xfer               = bus.in_valid[gnt_reg] && slot_free;
            if (xfer) begin
               cnt_next = cnt_reg + 1'b1;
               rel_now  = bus.in_tail[gnt_reg] ||
                          ((BURST_LIMIT != 0) && (int'(cnt_reg) + 1 == BURST_LIMIT));
               if (rel_now) begin
                  state_next = ARB_IDLE;
                  ptr_next   = gnt_reg + 2'd1;
                  cnt_next   = '0;
               end
            end
         end
         default: state_next = ARB_IDLE;
      endcase

      if (xfer) begin
         valid_next = 1'b1;
         tail_next  = bus.in_tail[gnt_reg];
         data_next  = bus.in_data[gnt_reg];
         src_next   = gnt_reg;
      end else if (valid_reg && bus.out_ready) begin
         valid_next = 1'b0;
      end
   end

   assign bus.in_ready  = ready_vec;
   assign bus.out_valid = valid_reg;
   assign bus.out_tail  = tail_reg;
   assign bus.out_data  = data_reg;
   assign bus.out_src   = src_reg;
   assign bus.busy      = (state_reg == ARB_LOCKED);
endmodule

// File: tb/tb_rr_output_arbiter.sv
// Bench for rr_output_arbiter: one instance without and one with a burst limit of 2.
module tb_rr_output_arbiter;
   import router_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rr_output_arbiter_if #(.n(32)) bus0 ();
   rr_output_arbiter_if #(.n(32)) bus2 ();

   rr_output_arbiter #(.n(32), .BURST_LIMIT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   rr_output_arbiter #(.n(32), .BURST_LIMIT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   logic [3:0]        iv [2];
   logic [3:0]        it [2];
   logic [3:0][31:0]  id [2];
   logic              ordy;
   logic [3:0]        hold;
   logic [3:0]        gate;

   logic [3:0]  rdy [2];
   logic        ov  [2];
   logic        ot  [2];
   logic        bz  [2];
   logic [31:0] od  [2];
   logic [1:0]  os  [2];

   assign bus0.in_valid  = iv[0];
   assign bus0.in_tail   = it[0];
   assign bus0.in_data   = id[0];
   assign bus0.out_ready = ordy;
   assign bus2.in_valid  = iv[1];
   assign bus2.in_tail   = it[1];
   assign bus2.in_data   = id[1];
   assign bus2.out_ready = ordy;

   assign rdy[0] = bus0.in_ready;  assign rdy[1] = bus2.in_ready;
   assign ov[0]  = bus0.out_valid; assign ov[1]  = bus2.out_valid;
   assign ot[0]  = bus0.out_tail;  assign ot[1]  = bus2.out_tail;
   assign bz[0]  = bus0.busy;      assign bz[1]  = bus2.busy;
   assign od[0]  = bus0.out_data;  assign od[1]  = bus2.out_data;
   assign os[0]  = bus0.out_src;   assign os[1]  = bus2.out_src;

   // Per-requester flit sources {tail, data} and accepted-output logs {src, tail, data}.
   logic [32:0] srcq [2][4][$];
   logic [34:0] logq [2][$];
   logic [34:0] expq [$];

   // Behavioural reference: lock flag, pointer, grant, flit count, output slot.
   int          lim [2] = '{0, 2};
   int          m_locked [2], m_ptr [2], m_gnt [2], m_cnt [2], m_ov [2], m_ot [2], m_os [2];
   logic [31:0] m_od [2];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [34:0] ent(input int s, input bit t, input logic [31:0] dat);
      return {2'(s), t, dat};
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_locked[d] = 0; m_ptr[d] = 0; m_gnt[d] = 0; m_cnt[d] = 0;
         m_ov[d] = 0; m_ot[d] = 0; m_os[d] = 0; m_od[d] = '0;
      end
   endtask

   task automatic model_step(input int d);
      int  g;
      bit  found;
      bit  room;
      room = (m_ov[d] == 0) || ordy;
      if (m_locked[d] == 0) begin
         found = 0;
         for (int k = 0; k < 4; k++) begin
            if (!found && iv[d][(m_ptr[d] + k) % 4]) begin
               found = 1;
               m_gnt[d] = (m_ptr[d] + k) % 4;
            end
         end
         if (found) begin
            m_locked[d] = 1;
            m_cnt[d] = 0;
         end
         if (m_ov[d] != 0 && ordy) m_ov[d] = 0;
      end else begin
         g = m_gnt[d];
         if (iv[d][g] && room) begin
            m_ov[d] = 1; m_od[d] = id[d][g]; m_ot[d] = int'(it[d][g]); m_os[d] = g;
            m_cnt[d]++;
            if (it[d][g] || (lim[d] != 0 && m_cnt[d] == lim[d])) begin
               m_locked[d] = 0;
               m_ptr[d] = (g + 1) % 4;
               m_cnt[d] = 0;
            end
         end else if (m_ov[d] != 0 && ordy) begin
            m_ov[d] = 0;
         end
      end
   endtask

   task automatic push(input int r, input logic [31:0] dat, input bit tail);
      for (int d = 0; d < 2; d++) srcq[d][r].push_back({tail, dat});
   endtask

   task automatic clear_logs();
      for (int d = 0; d < 2; d++) logq[d].delete();
   endtask

   // One clock: drive sources, check against the model, then advance both.
   task automatic cycle();
      logic [3:0]  rs [2];
      logic [3:0]  exp_rdy;
      logic [32:0] f;
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 4; r++) begin
            if (srcq[d][r].size() > 0 && !hold[r] && gate[r]) begin
               f = srcq[d][r][0];
               iv[d][r] = 1'b1; it[d][r] = f[32]; id[d][r] = f[31:0];
            end else begin
               iv[d][r] = 1'b0; it[d][r] = 1'b0; id[d][r] = 32'hDEAD_0000 | r;
            end
         end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         exp_rdy = 4'b0;
         if (m_locked[d] != 0 && (m_ov[d] == 0 || ordy)) exp_rdy[m_gnt[d]] = 1'b1;
         check($sformatf("in_ready[%0d]", d), rdy[d], exp_rdy);
         check($sformatf("out_valid[%0d]", d), ov[d], m_ov[d]);
         check($sformatf("busy[%0d]", d), bz[d], m_locked[d]);
         check($sformatf("out_data[%0d]", d), od[d], m_od[d]);
         check($sformatf("out_tail[%0d]", d), ot[d], m_ot[d]);
         check($sformatf("out_src[%0d]", d), os[d], m_os[d]);
         if (ov[d] && ordy) logq[d].push_back({os[d], ot[d], od[d]});
         rs[d] = rdy[d];
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) model_step(d);
      for (int d = 0; d < 2; d++)
         for (int r = 0; r < 4; r++)
            if (rs[d][r] && iv[d][r] && srcq[d][r].size() > 0) void'(srcq[d][r].pop_front());
      #1;
   endtask

   task automatic drain();
      bit idle;
      int budget;
      idle = 0;
      budget = 300;
      while (!idle && budget > 0) begin
         cycle();
         budget--;
         idle = !ov[0] && !ov[1] && !bz[0] && !bz[1];
         for (int d = 0; d < 2; d++)
            for (int r = 0; r < 4; r++)
               if (srcq[d][r].size() > 0) idle = 0;
      end
      check("drain_done", idle, 1);
   endtask

   task automatic wait_log(input int d, input int cnt);
      int budget;
      budget = 60;
      while (logq[d].size() < cnt && budget > 0) begin
         cycle();
         budget--;
      end
      check("wait_log", logq[d].size() >= cnt, 1);
   endtask

   task automatic expect_log(input int d, input string tag);
      check({tag, "_len"}, logq[d].size(), expq.size());
      for (int i = 0; i < expq.size() && i < logq[d].size(); i++)
         check($sformatf("%s_%0d", tag, i), logq[d][i], expq[i]);
   endtask

   task automatic check_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         check({tag, "_in_ready"}, rdy[d], 0);
         check({tag, "_out_valid"}, ov[d], 0);
         check({tag, "_out_tail"}, ot[d], 0);
         check({tag, "_out_data"}, od[d], 0);
         check({tag, "_out_src"}, os[d], 0);
         check({tag, "_busy"}, bz[d], 0);
      end
   endtask

   initial begin
      int          budget;
      int          n_pushed;
      int          r;
      int          len;
      logic [31:0] held;

      ordy = 1'b1; hold = 4'h0; gate = 4'hF;
      for (int d = 0; d < 2; d++) begin iv[d] = '0; it[d] = '0; id[d] = '0; end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b1;

      // Rotation: two single-flit packets per requester.
      for (int k = 0; k < 4; k++) push(k, 32'h10 + k, 1);
      for (int k = 0; k < 4; k++) push(k, 32'h20 + k, 1);
      drain();
      expq.delete();
      for (int k = 0; k < 4; k++) expq.push_back(ent(k, 1, 32'h10 + k));
      for (int k = 0; k < 4; k++) expq.push_back(ent(k, 1, 32'h20 + k));
      expect_log(0, "rotation");
      expect_log(1, "rotation_lim");
      clear_logs();

      // Packet lock: port2 three-flit packet while loopback waits.
      push(1, 32'hA1, 0); push(1, 32'hA2, 0); push(1, 32'hA3, 1); push(3, 32'hB0, 1);
      wait_log(0, 3);
      check("lock_ptr", dut0.ptr_reg, 2);
      drain();
      expq.delete();
      expq.push_back(ent(1, 0, 32'hA1)); expq.push_back(ent(1, 0, 32'hA2));
      expq.push_back(ent(1, 1, 32'hA3)); expq.push_back(ent(3, 1, 32'hB0));
      expect_log(0, "lock");
      expq.delete();
      expq.push_back(ent(1, 0, 32'hA1)); expq.push_back(ent(1, 0, 32'hA2));
      expq.push_back(ent(3, 1, 32'hB0)); expq.push_back(ent(1, 1, 32'hA3));
      expect_log(1, "lock_lim");
      clear_logs();

      // Backpressure: hold out_ready low for five cycles with the slot full.
      push(0, 32'hC0, 0); push(0, 32'hC1, 0); push(0, 32'hC2, 1);
      budget = 50;
      while (!ov[0] && budget > 0) begin cycle(); budget--; end
      check("bp_filled", ov[0], 1);
      ordy = 1'b0;
      held = od[0];
      repeat (5) begin
         cycle();
         check("bp_ready", rdy[0], 0);
         check("bp_valid", ov[0], 1);
         check("bp_data", od[0], held);
      end
      ordy = 1'b1;
      drain();
      expq.delete();
      expq.push_back(ent(0, 0, 32'hC0)); expq.push_back(ent(0, 0, 32'hC1));
      expq.push_back(ent(0, 1, 32'hC2));
      expect_log(0, "bp");
      expect_log(1, "bp_lim");
      clear_logs();

      // Burst limit: five-flit packet on port1, port3 arrives once port1 is locked.
      for (int k = 1; k <= 5; k++) push(0, 32'hD0 + k, k == 5);
      cycle();
      push(2, 32'hE1, 1);
      drain();
      expq.delete();
      for (int k = 1; k <= 5; k++) expq.push_back(ent(0, k == 5, 32'hD0 + k));
      expq.push_back(ent(2, 1, 32'hE1));
      expect_log(0, "burst_nolim");
      expq.delete();
      expq.push_back(ent(0, 0, 32'hD1)); expq.push_back(ent(0, 0, 32'hD2));
      expq.push_back(ent(2, 1, 32'hE1));
      expq.push_back(ent(0, 0, 32'hD3)); expq.push_back(ent(0, 0, 32'hD4));
      expq.push_back(ent(0, 1, 32'hD5));
      expect_log(1, "burst");
      clear_logs();

      // Stall: port3 drops valid mid-packet while port1 requests.
      push(2, 32'hF1, 0); push(2, 32'hF2, 0); push(2, 32'hF3, 1);
      wait_log(0, 1);
      hold[2] = 1'b1;
      push(0, 32'h61, 1);
      repeat (4) begin
         cycle();
         check("stall_busy", bz[0], 1);
         check("stall_no_grant", rdy[0][0], 0);
      end
      hold[2] = 1'b0;
      drain();
      expq.delete();
      expq.push_back(ent(2, 0, 32'hF1)); expq.push_back(ent(2, 0, 32'hF2));
      expq.push_back(ent(2, 1, 32'hF3)); expq.push_back(ent(0, 1, 32'h61));
      expect_log(0, "stall");
      expq.delete();
      expq.push_back(ent(2, 0, 32'hF1)); expq.push_back(ent(2, 0, 32'hF2));
      expq.push_back(ent(0, 1, 32'h61)); expq.push_back(ent(2, 1, 32'hF3));
      expect_log(1, "stall_lim");
      clear_logs();

      // Random traffic, gaps and backpressure against the model.
      n_pushed = 0;
      for (int c = 0; c < 400; c++) begin
         gate = 4'($urandom);
         ordy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) begin
            r = $urandom_range(0, 3);
            if (srcq[0][r].size() < 6) begin
               len = $urandom_range(1, 4);
               for (int k = 0; k < len; k++) push(r, $urandom, k == len - 1);
               n_pushed += len;
            end
         end
         cycle();
      end
      gate = 4'hF;
      ordy = 1'b1;
      drain();
      check("random_count0", logq[0].size(), n_pushed);
      check("random_count2", logq[1].size(), n_pushed);
      clear_logs();

      // Asynchronous reset with a flit in the output register.
      push(1, 32'h71, 0); push(1, 32'h72, 0); push(1, 32'h73, 1);
      budget = 50;
      while (!ov[0] && budget > 0) begin cycle(); budget--; end
      check("rst_pre_valid", ov[0], 1);
      #2 rst = 1'b0;
      #1;
      check_zero("async_rst");
      for (int d = 0; d < 2; d++) for (int k = 0; k < 4; k++) srcq[d][k].delete();
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      clear_logs();
      for (int k = 0; k < 4; k++) push(k, 32'h80 + k, 1);
      drain();
      expq.delete();
      for (int k = 0; k < 4; k++) expq.push_back(ent(k, 1, 32'h80 + k));
      expect_log(0, "post_rst");
      expect_log(1, "post_rst_lim");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end
endmodule
